// File: rtl/cpu_pkg.sv
// Shared CPU constants: register bank geometry and writeback requester IDs.
package cpu_pkg;
  localparam int DATA_W  = 16;
  localparam int NREGS   = 8;
  localparam int ADDR_W  = 3;
  localparam int REQ_ALU = 0;
  localparam int REQ_LD  = 1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. prio_q names the requester favoured on a tie.
// It moves only when a grant is issued.
module rr_arbiter2
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  logic prio_q, prio_d;

  always_comb begin
    grant  = 2'b00;
    prio_d = prio_q;
    if (!rst) begin
      if (req == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
      else              grant = req;
    end
    // The winner hands priority to the other requester.
    if (grant[REQ_ALU])     prio_d = 1'b1;
    else if (grant[REQ_LD]) prio_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares one register-bank write port between the ALU and load writeback paths.
// Acks are combinational. The chosen write is registered onto reg_we/reg_din.
module regfile_write_arbiter #(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int NREGS    = cpu_pkg::NREGS,
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic [NREGS-1:0]  reg_we,
  output logic [DATA_W-1:0] reg_din,
  output logic [CNT_W-1:0]  conflict_cnt
);
  import cpu_pkg::*;

  logic [1:0]        grant;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              wr_en;
  logic [NREGS-1:0]  reg_we_q, reg_we_d;
  logic [DATA_W-1:0] reg_din_q, reg_din_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   ({req1, req0}),
    .grant (grant)
  );

  assign ack0 = grant[REQ_ALU];
  assign ack1 = grant[REQ_LD];

  always_comb begin
    win_addr  = grant[REQ_LD] ? addr1 : addr0;
    win_data  = grant[REQ_LD] ? data1 : data0;
    // A write to a read-only R0 is still acked, but it is dropped here.
    wr_en     = (|grant) && !(ZERO_REG && (win_addr == '0));
    reg_we_d  = '0;
    reg_din_d = reg_din_q;
    if (wr_en) begin
      reg_we_d  = NREGS'(1) << win_addr;
      reg_din_d = win_data;
    end
    cnt_d = cnt_q;
    if (req0 && req1 && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_we_q  <= '0;
      reg_din_q <= '0;
      cnt_q     <= '0;
    end else begin
      reg_we_q  <= reg_we_d;
      reg_din_q <= reg_din_d;
      cnt_q     <= cnt_d;
    end
  end

  assign reg_we       = reg_we_q;
  assign reg_din      = reg_din_q;
  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized requesters.
// Results are compared against a cycle-level reference model and a modelled register bank.
module tb_regfile_write_arbiter;
  localparam int DW = 16, NR = 8, AW = 3, CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          ack0, ack1;
  logic [NR-1:0] reg_we;
  logic [DW-1:0] reg_din;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(DW), .NREGS(NR), .ADDR_W(AW), .ZERO_REG(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1),
    .reg_we(reg_we), .reg_din(reg_din), .conflict_cnt(conflict_cnt)
  );

  // Register bank fed by the DUT's write port.
  logic [DW-1:0] bank [NR];
  always_ff @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (rst)            bank[i] <= '0;
      else if (reg_we[i]) bank[i] <= reg_din;
    end
  end

  // Reference model state
  int            m_prio, m_cnt, last_g;
  logic [NR-1:0] m_we;
  logic [DW-1:0] m_din;
  logic [DW-1:0] m_bank [NR];
  int            errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_prio = 0; m_cnt = 0; m_we = '0; m_din = '0;
    for (int i = 0; i < NR; i++) m_bank[i] = '0;
  endtask

  // Drive one clock cycle. Check mid-cycle, then advance the model across the edge.
  task automatic cycle(input logic r, input logic q0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic q1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int g;
    logic [AW-1:0] wa;
    rst = r; req0 = q0; addr0 = a0; data0 = d0; req1 = q1; addr1 = a1; data1 = d1;
    @(negedge clk);
    if (r)             g = -1;
    else if (q0 && q1) g = m_prio;
    else if (q0)       g = 0;
    else if (q1)       g = 1;
    else               g = -1;
    chk("ack0", 32'(ack0), 32'(g == 0));
    chk("ack1", 32'(ack1), 32'(g == 1));
    chk("reg_we", 32'(reg_we), 32'(m_we));
    chk("reg_din", 32'(reg_din), 32'(m_din));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    chk("we_onehot", 32'($countones(reg_we) <= 1), 32'd1);
    for (int i = 0; i < NR; i++) chk($sformatf("bank%0d", i), 32'(bank[i]), 32'(m_bank[i]));
    last_g = g;
    if (r) model_reset();
    else begin
      for (int i = 0; i < NR; i++) if (m_we[i]) m_bank[i] = m_din;
      if (q0 && q1 && m_cnt < (1 << CW) - 1) m_cnt++;
      m_we = '0;
      if (g >= 0) begin
        m_prio = 1 - g;
        wa = (g == 1) ? a1 : a0;
        if (wa != 0) begin
          m_we  = NR'(1) << wa;
          m_din = (g == 1) ? d1 : d0;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic          p0, p1, r;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] rd0, rd1;
    rst = 1'b1; req0 = 0; req1 = 0; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    @(posedge clk); #1;
    model_reset();

    // 1: reset with a pending request
    cycle(1, 1, 3, 16'hBEEF, 0, 0, 0);
    cycle(1, 1, 3, 16'hBEEF, 0, 0, 0);
    chk("t1_we", 32'(reg_we), 32'h0);
    chk("t1_cnt", 32'(conflict_cnt), 32'h0);

    // 2: single write, two-cycle latency into the bank
    cycle(0, 1, 3, 16'hBEEF, 0, 0, 0);
    chk("t2_we", 32'(reg_we), 32'h08);
    chk("t2_din", 32'(reg_din), 32'hBEEF);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("t2_r3", 32'(bank[3]), 32'hBEEF);

    // 3: contention alternates from a fresh reset
    cycle(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cycle(0, 1, 1, 16'hAAAA, 1, 2, 16'hBBBB);
    chk("t3_cnt", 32'(conflict_cnt), 32'd4);
    chk("t3_we", 32'(reg_we), 32'h04);

    // 4: write to R0 is acked but dropped, then a normal write
    cycle(0, 0, 0, 0, 1, 0, 16'h1234);
    chk("t4_we0", 32'(reg_we), 32'h0);
    cycle(0, 0, 0, 0, 1, 5, 16'h5555);
    chk("t4_we5", 32'(reg_we), 32'h20);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("t4_r0", 32'(bank[0]), 32'h0);
    chk("t4_r5", 32'(bank[5]), 32'h5555);

    // 5: both target R6; the later grant wins
    cycle(0, 1, 6, 16'h0001, 1, 6, 16'h0002);
    cycle(0, 0, 0, 0, 1, 6, 16'h0002);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("t5_r6", 32'(bank[6]), 32'h0002);

    // 6: saturation, then reset mid-grant
    for (int k = 0; k < 300; k++) cycle(0, 1, 1, DW'(k), 1, 2, DW'(~k));
    chk("t6_sat", 32'(conflict_cnt), 32'd255);
    cycle(1, 1, 1, 16'h7777, 1, 2, 16'h8888);
    chk("t6_we", 32'(reg_we), 32'h0);
    chk("t6_cnt", 32'(conflict_cnt), 32'h0);
    cycle(0, 1, 1, 16'h7777, 1, 2, 16'h8888);

    // Randomized requesters that hold their request until acked
    p0 = 0; p1 = 0; ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
    for (int k = 0; k < 300; k++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1; ra0 = AW'($urandom); rd0 = DW'($urandom); end
      if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1; ra1 = AW'($urandom); rd1 = DW'($urandom); end
      r = ($urandom_range(0, 59) == 0);
      cycle(r, p0, ra0, rd0, p1, ra1, rd1);
      if (last_g == 0) p0 = 0;
      if (last_g == 1) p1 = 0;
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
